// File: rtl/dsp48_mac_sequencer_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate sequencer.
package dsp48_pkg;

    localparam int AB_W  = 18;
    localparam int P_W   = 48;
    localparam int OPM_W = 8;

    localparam logic [OPM_W-1:0] OPM_FIRST = 8'h01;
    localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;
    localparam logic [OPM_W-1:0] OPM_HOLD  = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/dsp48_mac_sequencer_if.sv
// Operand-beat and result handshakes between a producer/consumer and the sequencer.
interface dsp48_mac_sequencer_if #(
    parameter int LEN_W = 13
);
    import dsp48_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [AB_W-1:0]   in_a;
    logic [AB_W-1:0]   in_b;
    logic              in_last;
    logic              res_valid;
    logic              res_ready;
    logic [P_W-1:0]    res_data;
    logic [LEN_W-1:0]  res_len;
    logic              res_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_len, res_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, res_ready,
        output in_ready, res_valid, res_data, res_len, res_ovf
    );

endinterface

// File: rtl/dsp48_mac_sequencer.sv
// Feeds operand pairs to a DSP48A1 slice as a MAC engine and returns one
// 48-bit dot product per vector, aligned to the slice's register pipeline.
module dsp48_mac_sequencer
    import dsp48_pkg::*;
#(
    parameter int DSP_LAT = 3,
    parameter int MAX_LEN = 4096,
    parameter int LEN_W   = 13
) (
    input  logic                 clk1,
    input  logic                 rstn,
    dsp48_mac_sequencer_if.slave bus,
    output logic [AB_W-1:0]      dsp_a,
    output logic [AB_W-1:0]      dsp_b,
    output logic [OPM_W-1:0]     dsp_opmode,
    output logic                 dsp_ce,
    output logic                 dsp_rst,
    input  logic [P_W-1:0]       dsp_p
);

    localparam int               DW        = $clog2(DSP_LAT + 1);
    localparam logic [LEN_W:0]   MAX_LEN_V = (LEN_W + 1)'(MAX_LEN);

    state_t            state;
    logic [DW-1:0]     drain_cnt;
    logic              beat_d;
    logic              first_d;
    logic [LEN_W-1:0]  len_cnt;
    logic [LEN_W-1:0]  len_next;
    logic              ovf;
    logic              accept;
    logic              first_beat;

    assign bus.in_ready = ((state == ST_IDLE) || (state == ST_ACCUM)) && !dsp_rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign first_beat   = (state == ST_IDLE);
    assign bus.res_len  = len_cnt;
    assign bus.res_ovf  = ovf;

    always_comb begin
        len_next = len_cnt;
        if (first_beat)
            len_next = LEN_W'(1);
        else if (len_cnt != '1)
            len_next = len_cnt + LEN_W'(1);
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            drain_cnt     <= '0;
            beat_d        <= 1'b0;
            first_d       <= 1'b0;
            len_cnt       <= '0;
            ovf           <= 1'b0;
            dsp_a         <= '0;
            dsp_b         <= '0;
            dsp_opmode    <= OPM_HOLD;
            dsp_ce        <= 1'b0;
            dsp_rst       <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
        end else begin
            dsp_rst <= 1'b0;
            dsp_ce  <= 1'b1;

            // Opmode trails the operands by one cycle so the slice's OPMODE
            // register lines up with its M register.
            beat_d     <= accept;
            first_d    <= first_beat;
            dsp_opmode <= beat_d ? (first_d ? OPM_FIRST : OPM_ACC) : OPM_HOLD;

            if (accept) begin
                dsp_a     <= bus.in_a;
                dsp_b     <= bus.in_b;
                len_cnt   <= len_next;
                ovf       <= (!first_beat && ovf) || ({1'b0, len_next} > MAX_LEN_V);
                drain_cnt <= DW'(DSP_LAT);
            end

            case (state)
                ST_IDLE: begin
                    if (accept)
                        state <= bus.in_last ? ST_DRAIN : ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (accept && bus.in_last)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state         <= ST_RESULT;
                        bus.res_valid <= 1'b1;
                        bus.res_data  <= dsp_p;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                ST_RESULT: begin
                    if (bus.res_ready) begin
                        state         <= ST_IDLE;
                        bus.res_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
